// File: rtl/conv_pkg.sv
// Shared definitions for the 1x3 convolution pipeline blocks: FSM encoding and
// default geometry/format constants.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          DEF_D          = 299;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_ADDR_W     = 17;
    localparam logic [31:0] FP32_ONE       = 32'h3f800000;

    // Number of pixels in a square frame of side d.
    function automatic longint frame_pixels(input int d);
        return longint'(d) * longint'(d);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order position tracker for a square D x D frame: row, column and a
// running linear address, wrapping to the origin after the last pixel.
module raster_counter
    import conv_pkg::*;
#(
    parameter int D      = DEF_D,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(D - 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_s;

    assign last_s = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // Next position; the address runs alongside row/col instead of row*D+col.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            if (last_s) begin
                row_d  = '0;
                col_d  = '0;
                addr_d = '0;
            end else if (col_q == LAST_IDX) begin
                row_d  = row_q + ADDR_W'(1);
                col_d  = '0;
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                row_d  = row_q;
                col_d  = col_q + ADDR_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            row_d  = row_q;
            col_d  = col_q;
            addr_d = addr_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign addr = addr_q;
    assign last = last_s;

endmodule

// File: rtl/conv_frame_writer.sv
// Writes one D x D raster pixel stream into a frame buffer write port.
// Optional CONV_FRAME_WRITER_CHECKSUM_EN adds an XOR checksum of the written frame.
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int D          = DEF_D,
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic [ADDR_W-1:0]     row,
    output logic [ADDR_W-1:0]     col,
    output logic                  overrun
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
    ,
    output logic [data_width-1:0] checksum
`endif
);

    state_t                state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  cnt_clear_s;
    logic                  cnt_adv_s;
    logic [ADDR_W-1:0]     cnt_addr_s;
    logic                  cnt_last_s;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
    logic [data_width-1:0] checksum_q, checksum_d;
`endif

    raster_counter #(
        .D      (D),
        .ADDR_W (ADDR_W)
    ) u_raster_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .advance (cnt_adv_s),
        .row     (row),
        .col     (col),
        .addr    (cnt_addr_s),
        .last    (cnt_last_s)
    );

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        cnt_clear_s  = 1'b0;
        cnt_adv_s    = 1'b0;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        if (abort) begin
            state_d     = ST_IDLE;
            cnt_clear_s = 1'b1;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
            checksum_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // A pixel arriving with start is still dropped and flagged.
                        state_d     = ST_RUN;
                        cnt_clear_s = 1'b1;
                        overrun_d   = valid_in;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
                        checksum_d  = '0;
`endif
                    end else if (valid_in) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                ST_RUN: begin
                    if (valid_in) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_addr_s;
                        mem_wdata_d = pxl_in;
                        cnt_adv_s   = 1'b1;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
                        checksum_d  = checksum_q ^ pxl_in;
`endif
                        if (cnt_last_s) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (valid_in) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_clear_s = 1'b1;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
    // Running XOR of the pixels written in the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer with a 4x4 frame: table-driven control
// vectors followed by full-frame, gapped, abort, reset and checksum sequences.
module tb_conv_frame_writer;

    localparam int D  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          overrun;
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    conv_frame_writer #(
        .D          (D),
        .data_width (DW),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .valid_in   (valid_in),
        .pxl_in     (pxl_in),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .row        (row),
        .col        (col),
        .overrun    (overrun)
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        valid;
        logic [31:0] pxl;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        done;
        logic        busy;
        logic        ovr;
        logic [4:0]  row;
        logic [4:0]  col;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pix(input int mode, input int i);
        if (mode == 1) return (i == 0) ? 32'h3f800000 : 32'h0;
        return 32'h0000_0100 + 32'(i) * 32'h0000_0011 + 32'(mode) * 32'h0001_0000;
    endfunction

    // Start a frame and stream 16 pixels with 'gap' idle cycles before each.
    task automatic run_frame(input int gap, input int mode, input string tag);
        logic [31:0] sum;
        logic [31:0] p;
        sum = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy after start"}, {31'h0, busy}, 32'd1);
        chk({tag, " ovr after start"}, {31'h0, overrun}, 32'd0);
        chk({tag, " we after start"}, {31'h0, mem_we}, 32'd0);
        for (int i = 0; i < D * D; i++) begin
            for (int g = 0; g < gap; g++) begin
                valid_in = 1'b0;
                tick();
                chk({tag, " we in gap"}, {31'h0, mem_we}, 32'd0);
                chk({tag, " done in gap"}, {31'h0, frame_done}, 32'd0);
            end
            chk({tag, " row"}, {27'h0, row}, 32'(i / D));
            chk({tag, " col"}, {27'h0, col}, 32'(i % D));
            p = pix(mode, i);
            sum = sum ^ p;
            valid_in = 1'b1;
            pxl_in = p;
            tick();
            valid_in = 1'b0;
            pxl_in = 32'hDEAD_BEEF;
            chk({tag, " we"}, {31'h0, mem_we}, 32'd1);
            chk({tag, " addr"}, {27'h0, mem_addr}, 32'(i));
            chk({tag, " wdata"}, mem_wdata, p);
            chk({tag, " done"}, {31'h0, frame_done}, (i == D * D - 1) ? 32'd1 : 32'd0);
            chk({tag, " busy"}, {31'h0, busy}, (i == D * D - 1) ? 32'd0 : 32'd1);
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
            chk({tag, " checksum"}, checksum, sum);
`endif
        end
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
        if (mode == 1) chk({tag, " checksum fp32 one"}, checksum, 32'h3f800000);
`endif
        tick();
        chk({tag, " we after done"}, {31'h0, mem_we}, 32'd0);
        chk({tag, " done pulse width"}, {31'h0, frame_done}, 32'd0);
        chk({tag, " busy after done"}, {31'h0, busy}, 32'd0);
        chk({tag, " row wrap"}, {27'h0, row}, 32'd0);
        chk({tag, " col wrap"}, {27'h0, col}, 32'd0);
    endtask

    // Start and write n pixels without finishing the frame.
    task automatic partial(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            pxl_in = 32'h0000_0A00 + 32'(i);
            tick();
            chk("partial addr", {27'h0, mem_addr}, 32'(i));
        end
        valid_in = 1'b0;
    endtask

    initial begin
        //         st    ab    vld   pxl       we    addr  wdata     done  busy  ovr   row   col
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hAA,  1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hAB,  1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b1, 1'b0, 5'd0, 5'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 5'd0, 32'h100, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b1, 1'b0, 5'd0, 5'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h101, 1'b1, 5'd1, 32'h101, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h5,   1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h6,   1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h7,   1'b0, 5'd0, 32'h0,   1'b0, 1'b1, 1'b1, 5'd0, 5'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b1, 1'b0, 5'd0, 5'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 5'd0, 5'd0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        valid_in = 1'b0;
        pxl_in = 32'h0;
        #23;
        chk("reset we", {31'h0, mem_we}, 32'd0);
        chk("reset busy", {31'h0, busy}, 32'd0);
        chk("reset ovr", {31'h0, overrun}, 32'd0);
        chk("reset row", {27'h0, row}, 32'd0);
        chk("reset col", {27'h0, col}, 32'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 13; v++) begin
            start = tbl[v].start;
            abort = tbl[v].abort;
            valid_in = tbl[v].valid;
            pxl_in = tbl[v].pxl;
            tick();
            chk($sformatf("vec%0d we", v), {31'h0, mem_we}, {31'h0, tbl[v].we});
            if (tbl[v].we) begin
                chk($sformatf("vec%0d addr", v), {27'h0, mem_addr}, {27'h0, tbl[v].addr});
                chk($sformatf("vec%0d wdata", v), mem_wdata, tbl[v].wdata);
            end
            chk($sformatf("vec%0d done", v), {31'h0, frame_done}, {31'h0, tbl[v].done});
            chk($sformatf("vec%0d busy", v), {31'h0, busy}, {31'h0, tbl[v].busy});
            chk($sformatf("vec%0d ovr", v), {31'h0, overrun}, {31'h0, tbl[v].ovr});
            chk($sformatf("vec%0d row", v), {27'h0, row}, {27'h0, tbl[v].row});
            chk($sformatf("vec%0d col", v), {27'h0, col}, {27'h0, tbl[v].col});
        end
        start = 1'b0;
        abort = 1'b0;
        valid_in = 1'b0;

        run_frame(0, 0, "basic");
        run_frame(2, 2, "gapped");

        valid_in = 1'b1;
        pxl_in = 32'h55;
        tick();
        tick();
        valid_in = 1'b0;
        chk("idle ovr we", {31'h0, mem_we}, 32'd0);
        chk("idle ovr set", {31'h0, overrun}, 32'd1);
        run_frame(0, 3, "after ovr");

        partial(6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", {31'h0, busy}, 32'd0);
        chk("abort we", {31'h0, mem_we}, 32'd0);
        chk("abort done", {31'h0, frame_done}, 32'd0);
        chk("abort row", {27'h0, row}, 32'd0);
        chk("abort col", {27'h0, col}, 32'd0);
        tick();
        chk("abort no done", {31'h0, frame_done}, 32'd0);
        run_frame(0, 4, "after abort");

        partial(9);
        valid_in = 1'b1;
        pxl_in = 32'h0000_0A09;
        #3;
        reset = 1'b1;
        #1;
        chk("async rst we", {31'h0, mem_we}, 32'd0);
        chk("async rst addr", {27'h0, mem_addr}, 32'd0);
        chk("async rst wdata", mem_wdata, 32'd0);
        chk("async rst busy", {31'h0, busy}, 32'd0);
        chk("async rst row", {27'h0, row}, 32'd0);
        chk("async rst col", {27'h0, col}, 32'd0);
`ifdef CONV_FRAME_WRITER_CHECKSUM_EN
        chk("async rst checksum", checksum, 32'd0);
`endif
        valid_in = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        tick();
        chk("post rst idle busy", {31'h0, busy}, 32'd0);
        chk("post rst we", {31'h0, mem_we}, 32'd0);
        run_frame(0, 1, "checksum");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
